// File: rtl/tile_loader.sv
// Streams the tile set from the SD byte interface into tile RAM, two 4-bit pixels per byte.
// Optional TILE_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted bytes.
module tile_loader #(
  parameter logic [23:0] TILE_BASE_ADDR = 24'h000014,
  parameter int unsigned NUM_SECTORS    = 4,
  parameter int unsigned NUM_PIXELS     = 3872
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Start,
  output logic        SD_ReadReq,
  output logic [23:0] SD_ReadAddress,
  input  logic        SD_ReadAck,
  input  logic        SD_ByteValid,
  input  logic [7:0]  SD_ByteData,
  output logic        TileWrEn,
  output logic [11:0] TileWrAddr,
  output logic [3:0]  TileWrData,
  output logic        Busy,
  output logic        Done,
`ifdef TILE_LOADER_CHECKSUM_EN
  output logic        Overrun,
  output logic [15:0] Checksum
`else
  output logic        Overrun
`endif
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StRecv = 3'd2;
  localparam logic [2:0] StWrLo = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  stateQ, stateD;
  logic [7:0]  sectorQ, sectorD;
  logic [9:0]  byteCntQ, byteCntD;
  logic [12:0] pixelQ, pixelD;
  logic [3:0]  loNibQ, loNibD;
  logic        reqQ, reqD;
  logic [23:0] addrQ, addrD;
  logic        wrEnQ, wrEnD;
  logic [11:0] wrAddrQ, wrAddrD;
  logic [3:0]  wrDataQ, wrDataD;
  logic        busyQ, busyD;
  logic        doneQ, doneD;
  logic        overrunQ, overrunD;

  logic [9:0]  byteNext;
  logic        pixelInRange;
  logic        startLoad;

  assign startLoad = Start && (stateQ == StIdle || stateQ == StDone);

  always_comb begin
    stateD   = stateQ;
    sectorD  = sectorQ;
    byteCntD = byteCntQ;
    pixelD   = pixelQ;
    loNibD   = loNibQ;
    reqD     = reqQ;
    addrD    = addrQ;
    wrEnD    = 1'b0;
    wrAddrD  = wrAddrQ;
    wrDataD  = wrDataQ;
    busyD    = busyQ;
    doneD    = doneQ;
    overrunD = overrunQ;
    // A strobe landing in StWrLo is dropped but still counted to keep sector framing.
    byteNext     = byteCntQ + {9'd0, SD_ByteValid};
    pixelInRange = pixelQ < 13'(NUM_PIXELS);

    unique case (stateQ)
      StIdle, StDone: begin
        if (startLoad) begin
          stateD   = StReq;
          sectorD  = 8'd0;
          byteCntD = 10'd0;
          pixelD   = 13'd0;
          overrunD = 1'b0;
          doneD    = 1'b0;
          busyD    = 1'b1;
          reqD     = 1'b1;
          addrD    = TILE_BASE_ADDR;
        end
      end
      StReq: begin
        if (SD_ReadAck) begin
          reqD     = 1'b0;
          byteCntD = 10'd0;
          stateD   = StRecv;
        end
      end
      StRecv: begin
        if (SD_ByteValid) begin
          byteCntD = byteCntQ + 10'd1;
          loNibD   = SD_ByteData[3:0];
          wrEnD    = pixelInRange;
          if (pixelInRange) begin
            wrAddrD = pixelQ[11:0];
            wrDataD = SD_ByteData[7:4];
          end
          pixelD = pixelQ + 13'd1;
          stateD = StWrLo;
        end
      end
      StWrLo: begin
        wrEnD = pixelInRange;
        if (pixelInRange) begin
          wrAddrD = pixelQ[11:0];
          wrDataD = loNibQ;
        end
        pixelD   = pixelQ + 13'd1;
        byteCntD = byteNext;
        if (SD_ByteValid) overrunD = 1'b1;
        if (byteNext == 10'd512) begin
          if (sectorQ == 8'(NUM_SECTORS - 1)) begin
            stateD = StDone;
            busyD  = 1'b0;
            doneD  = 1'b1;
          end else begin
            sectorD = sectorQ + 8'd1;
            addrD   = TILE_BASE_ADDR + {16'd0, sectorQ + 8'd1};
            reqD    = 1'b1;
            stateD  = StReq;
          end
        end else begin
          stateD = StRecv;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      stateQ   <= StIdle;
      sectorQ  <= '0;
      byteCntQ <= '0;
      pixelQ   <= '0;
      loNibQ   <= '0;
      reqQ     <= 1'b0;
      addrQ    <= '0;
      wrEnQ    <= 1'b0;
      wrAddrQ  <= '0;
      wrDataQ  <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      sectorQ  <= sectorD;
      byteCntQ <= byteCntD;
      pixelQ   <= pixelD;
      loNibQ   <= loNibD;
      reqQ     <= reqD;
      addrQ    <= addrD;
      wrEnQ    <= wrEnD;
      wrAddrQ  <= wrAddrD;
      wrDataQ  <= wrDataD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      overrunQ <= overrunD;
    end
  end

  assign SD_ReadReq     = reqQ;
  assign SD_ReadAddress = addrQ;
  assign TileWrEn       = wrEnQ;
  assign TileWrAddr     = wrAddrQ;
  assign TileWrData     = wrDataQ;
  assign Busy           = busyQ;
  assign Done           = doneQ;
  assign Overrun        = overrunQ;

`ifdef TILE_LOADER_CHECKSUM_EN
  logic [15:0] sumQ, sumD;

  always_comb begin
    sumD = sumQ;
    if (startLoad) begin
      sumD = 16'd0;
    end else if (stateQ == StRecv && SD_ByteValid) begin
      sumD = sumQ + {8'd0, SD_ByteData};
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) sumQ <= '0;
    else       sumQ <= sumD;
  end

  assign Checksum = sumQ;
`endif

endmodule

// File: tb/tb_tile_loader.sv
// Directed bench for tile_loader: full load, nibble split at a tile boundary, overrun,
// mid-sector reset, ignored strobes/Start, and the optional checksum.
module tb_tile_loader;
  logic        MasterCLK = 1'b0;
  logic        Reset, Start, SD_ReadAck, SD_ByteValid;
  logic [7:0]  SD_ByteData;
  logic        SD_ReadReq, TileWrEn, Busy, Done, Overrun;
  logic [23:0] SD_ReadAddress;
  logic [11:0] TileWrAddr;
  logic [3:0]  TileWrData;
`ifdef TILE_LOADER_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  tile_loader dut (
    .MasterCLK     (MasterCLK),
    .Reset         (Reset),
    .Start         (Start),
    .SD_ReadReq    (SD_ReadReq),
    .SD_ReadAddress(SD_ReadAddress),
    .SD_ReadAck    (SD_ReadAck),
    .SD_ByteValid  (SD_ByteValid),
    .SD_ByteData   (SD_ByteData),
    .TileWrEn      (TileWrEn),
    .TileWrAddr    (TileWrAddr),
    .TileWrData    (TileWrData),
    .Busy          (Busy),
    .Done          (Done),
`ifdef TILE_LOADER_CHECKSUM_EN
    .Checksum      (Checksum),
`endif
    .Overrun       (Overrun)
  );

  always #5 MasterCLK = ~MasterCLK;

  int checks = 0;
  int failures = 0;
  logic [7:0]  pat [2048];
  logic [11:0] wrAddrLog[$];
  logic [3:0]  wrDataLog[$];

  always @(negedge MasterCLK) begin
    if (TileWrEn === 1'b1) begin
      wrAddrLog.push_back(TileWrAddr);
      wrDataLog.push_back(TileWrData);
    end
  end

  // Serves one sector: waits for the request, acks it, then sends strobes at 4-cycle spacing.
  task automatic load_sector(input int sec, input int nstrobes, input int dblAt,
                             input int startAt, input int base);
    int waitCnt;
    int strobes;
    int k;
    waitCnt = 0;
    while (SD_ReadReq !== 1'b1 && waitCnt < 100) begin
      @(negedge MasterCLK);
      waitCnt++;
    end
    checks++;
    if (SD_ReadReq !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout sector %0d: SD_ReadReq=%b expected 1", sec, SD_ReadReq);
      return;
    end
    checks++;
    if (SD_ReadAddress !== 24'h14 + 24'(sec)) begin
      failures++;
      $display("FAIL read_addr sector %0d: got %h expected %h", sec, SD_ReadAddress,
               24'h14 + 24'(sec));
    end
    SD_ReadAck = 1'b1;
    @(negedge MasterCLK);
    SD_ReadAck = 1'b0;
    checks++;
    if (SD_ReadReq !== 1'b0) begin
      failures++;
      $display("FAIL req_drop sector %0d: SD_ReadReq=%b expected 0", sec, SD_ReadReq);
    end
    strobes = 0;
    k = 0;
    while (strobes < nstrobes) begin
      SD_ByteValid = 1'b1;
      SD_ByteData  = pat[base + k];
      @(negedge MasterCLK);
      SD_ByteValid = 1'b0;
      strobes++;
      if (strobes == nstrobes) break;
      if (k == dblAt) begin
        SD_ByteValid = 1'b1;
        SD_ByteData  = 8'h77;
        @(negedge MasterCLK);
        SD_ByteValid = 1'b0;
        strobes++;
      end else begin
        @(negedge MasterCLK);
      end
      if (k == startAt) Start = 1'b1;
      @(negedge MasterCLK);
      Start = 1'b0;
      @(negedge MasterCLK);
      k++;
    end
    if (nstrobes == 512) begin
      checks++;
      if (SD_ReadReq !== 1'b0 || Done !== 1'b0) begin
        failures++;
        $display("FAIL end_t1 sector %0d: req=%b done=%b expected 0 0", sec, SD_ReadReq, Done);
      end
      @(negedge MasterCLK);
      if (sec == 3) begin
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
          failures++;
          $display("FAIL done_t2: done=%b busy=%b expected 1 0", Done, Busy);
        end
      end else begin
        checks++;
        if (SD_ReadReq !== 1'b1) begin
          failures++;
          $display("FAIL next_req sector %0d: req=%b expected 1", sec, SD_ReadReq);
        end
      end
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge MasterCLK);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; SD_ReadAck = 1'b0; SD_ByteValid = 1'b0; SD_ByteData = 8'h00;
    repeat (3) @(negedge MasterCLK);
    Reset = 1'b0;
    @(negedge MasterCLK);
    checks++;
    if ({SD_ReadReq, SD_ReadAddress, TileWrEn, TileWrAddr, TileWrData, Busy, Done, Overrun}
        !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b addr=%h we=%b wa=%h wd=%h busy=%b done=%b ovr=%b expected all 0",
               SD_ReadReq, SD_ReadAddress, TileWrEn, TileWrAddr, TileWrData, Busy, Done, Overrun);
    end
`ifdef TILE_LOADER_CHECKSUM_EN
    checks++;
    if (Checksum !== 16'd0) begin
      failures++;
      $display("FAIL reset_checksum: got %h expected 0000", Checksum);
    end
`endif
  endtask

  task automatic test_full_load();
    int bad;
    int firstBad;
    logic [3:0] exp;
    logic [15:0] expSum;
    for (int i = 0; i < 2048; i++) pat[i] = 8'h12;
    pat[60] = 8'hAB;
    wrAddrLog.delete();
    wrDataLog.delete();
    pulse_start();
    checks++;
    if (Busy !== 1'b1 || SD_ReadReq !== 1'b1) begin
      failures++;
      $display("FAIL start_t1: busy=%b req=%b expected 1 1", Busy, SD_ReadReq);
    end
    for (int s = 0; s < 4; s++) load_sector(s, 512, -1, (s == 0) ? 200 : -1, s * 512);
    @(negedge MasterCLK);
    checks++;
    if (wrAddrLog.size() !== 3872) begin
      failures++;
      $display("FAIL write_count: got %0d expected 3872", wrAddrLog.size());
    end
    bad = 0; firstBad = -1;
    for (int i = 0; i < wrAddrLog.size(); i++) begin
      if (wrAddrLog[i] !== 12'(i)) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_addr_order: %0d bad, first at write %0d, expected 0 bad", bad, firstBad);
    end
    bad = 0; firstBad = -1;
    for (int i = 0; i < wrDataLog.size(); i++) begin
      exp = (i == 120) ? 4'hA : (i == 121) ? 4'hB : (i % 2 == 0) ? 4'h1 : 4'h2;
      if (wrDataLog[i] !== exp) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_data: %0d bad, first at pixel %0d, expected 0 bad", bad, firstBad);
    end
    checks++;
    if (Overrun !== 1'b0) begin
      failures++;
      $display("FAIL no_overrun: got %b expected 0", Overrun);
    end
`ifdef TILE_LOADER_CHECKSUM_EN
    expSum = 16'd0;
    for (int i = 0; i < 2048; i++) expSum = expSum + {8'd0, pat[i]};
    checks++;
    if (Checksum !== expSum) begin
      failures++;
      $display("FAIL checksum_load: got %h expected %h", Checksum, expSum);
    end
`else
    expSum = 16'd0;
`endif
  endtask

  task automatic test_overrun();
    int sevens;
    for (int i = 0; i < 2048; i++) pat[i] = 8'h12;
    wrAddrLog.delete();
    wrDataLog.delete();
    pulse_start();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_done: done=%b busy=%b expected 0 1", Done, Busy);
    end
    load_sector(0, 512, 100, -1, 0);
    @(negedge MasterCLK);
    checks++;
    if (Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag: got %b expected 1", Overrun);
    end
    checks++;
    if (wrAddrLog.size() !== 1022) begin
      failures++;
      $display("FAIL overrun_writes: got %0d expected 1022", wrAddrLog.size());
    end
    sevens = 0;
    for (int i = 0; i < wrDataLog.size(); i++) if (wrDataLog[i] === 4'h7) sevens++;
    checks++;
    if (sevens != 0) begin
      failures++;
      $display("FAIL dropped_byte_written: got %0d writes of 7 expected 0", sevens);
    end
  endtask

  task automatic test_reset_mid();
    load_sector(1, 300, -1, -1, 512);
    Reset = 1'b1;
    @(negedge MasterCLK);
    Reset = 1'b0;
    checks++;
    if ({SD_ReadReq, SD_ReadAddress, TileWrEn, TileWrAddr, TileWrData, Busy, Done, Overrun}
        !== 45'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: req=%b addr=%h we=%b wa=%h wd=%h busy=%b done=%b ovr=%b expected all 0",
               SD_ReadReq, SD_ReadAddress, TileWrEn, TileWrAddr, TileWrData, Busy, Done, Overrun);
    end
    SD_ByteValid = 1'b1; SD_ByteData = 8'h55; SD_ReadAck = 1'b1;
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0; SD_ReadAck = 1'b0;
    @(negedge MasterCLK);
    checks++;
    if (Overrun !== 1'b0 || SD_ReadReq !== 1'b0 || Busy !== 1'b0 || TileWrEn !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: ovr=%b req=%b busy=%b we=%b expected 0 0 0 0",
               Overrun, SD_ReadReq, Busy, TileWrEn);
    end
    pulse_start();
    checks++;
    if (SD_ReadReq !== 1'b1 || SD_ReadAddress !== 24'h000014) begin
      failures++;
      $display("FAIL restart_addr: req=%b addr=%h expected 1 000014", SD_ReadReq, SD_ReadAddress);
    end
    Reset = 1'b1;
    @(negedge MasterCLK);
    Reset = 1'b0;
    @(negedge MasterCLK);
  endtask

`ifdef TILE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < 2048; i++) pat[i] = 8'hFF;
    pulse_start();
    for (int s = 0; s < 4; s++) load_sector(s, 512, -1, -1, s * 512);
    repeat (3) @(negedge MasterCLK);
    checks++;
    if (Checksum !== 16'hF800) begin
      failures++;
      $display("FAIL checksum_ff: got %h expected f800", Checksum);
    end
  endtask
`endif

  initial begin
    @(negedge MasterCLK);
    test_reset();
    test_full_load();
    test_overrun();
    test_reset_mid();
`ifdef TILE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
